// File: rtl/exception_ctrl_pkg.sv
// Shared types and constants for the exception controller: FSM states, ExcCode values, CP0 register map.
package exception_ctrl_pkg;

  typedef enum logic [1:0] {
    EXC_IDLE    = 2'd0,
    EXC_TAKE    = 2'd1,
    EXC_HANDLER = 2'd2
  } exc_state_t;

  localparam logic [4:0] EXC_CODE_INT = 5'd0;
  localparam logic [4:0] EXC_CODE_SYS = 5'd8;
  localparam logic [4:0] EXC_CODE_RI  = 5'd10;
  localparam logic [4:0] EXC_CODE_OV  = 5'd12;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  // Cause layout: IP[3:0] at bits 11:8, timer pending at bit 7, ExcCode at bits 6:2.
  function automatic logic [63:0] pack_cause(input logic [3:0] ip, input logic timer_ip,
                                             input logic [4:0] code);
    return {52'd0, ip, timer_ip, code, 2'b00};
  endfunction

endpackage

// File: rtl/exception_ctrl_timer.sv
// Count/Compare timer interrupt source; present only when EXC_TIMER_IRQ_EN is defined.
`ifdef EXC_TIMER_IRQ_EN
module exc_timer
  import exception_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [63:0] cp0_wdata,
  output logic [63:0] count,
  output logic [63:0] compare,
  output logic        pending
);

  logic compare_we;
  assign compare_we = cp0_we && (cp0_addr == CP0_COMPARE);

  // A Compare write acknowledges the interrupt, even if it lands on a match cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= '0;
      compare <= '0;
      pending <= 1'b0;
    end else begin
      count <= count + 64'd1;
      if (compare_we) begin
        compare <= cp0_wdata;
        pending <= 1'b0;
      end else if (count == compare) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/exception_ctrl.sv
// Exception/interrupt controller with CP0 Status/Cause/EPC.
// Optional timer interrupt (Count/Compare, IP[7]/IM[7]) is built when EXC_TIMER_IRQ_EN is defined.
module exception_ctrl
  import exception_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [63:0] ex_pc,
  input  logic        ex_bad_instr,
  input  logic        ex_overflow,
  input  logic        ex_syscall,
  input  logic [3:0]  irq_ext,
  input  logic        eret,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [63:0] cp0_wdata,
  output logic [63:0] cp0_rdata,
  output logic        takenHandler,
  output logic [63:0] EPC,
  output logic        exl
);

  exc_state_t state, state_next;

  logic [63:0] epc_q;
  logic        ie_q;
  logic [3:0]  im_q;
  logic [3:0]  ip_q;
  logic [4:0]  code_q;

  logic        timer_ip;
  logic        im7_q;

`ifdef EXC_TIMER_IRQ_EN
  logic [63:0] timer_count;
  logic [63:0] timer_compare;

  exc_timer u_timer (
    .clock     (clock),
    .reset     (reset),
    .cp0_we    (cp0_we),
    .cp0_addr  (cp0_addr),
    .cp0_wdata (cp0_wdata),
    .count     (timer_count),
    .compare   (timer_compare),
    .pending   (timer_ip)
  );

  always_ff @(posedge clock) begin
    if (reset)
      im7_q <= 1'b0;
    else if (cp0_we && (cp0_addr == CP0_STATUS))
      im7_q <= cp0_wdata[7];
  end
`else
  assign timer_ip = 1'b0;
  assign im7_q    = 1'b0;
`endif

  // Accept decision: synchronous exceptions need a real instruction; interrupts only need IE.
  logic       sync_exc;
  logic       irq_req;
  logic       accept;
  logic [4:0] accept_code;
  logic [63:0] accept_epc;

  assign sync_exc = ex_valid && (ex_bad_instr || ex_overflow || ex_syscall);
  assign irq_req  = ie_q && (((irq_ext & im_q) != 4'd0) || (timer_ip && im7_q));
  assign accept   = (state == EXC_IDLE) && (sync_exc || irq_req);

  always_comb begin
    accept_code = EXC_CODE_INT;
    if (sync_exc) begin
      if (ex_bad_instr)     accept_code = EXC_CODE_RI;
      else if (ex_overflow) accept_code = EXC_CODE_OV;
      else                  accept_code = EXC_CODE_SYS;
    end
  end

  // Interrupts resume after the interrupted instruction; wraps modulo 2^64.
  assign accept_epc = sync_exc ? ex_pc : ex_pc + 64'd4;

  always_ff @(posedge clock) begin
    if (reset) state <= EXC_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EXC_IDLE:    if (accept) state_next = EXC_TAKE;
      EXC_TAKE:    state_next = EXC_HANDLER;
      EXC_HANDLER: if (eret) state_next = EXC_IDLE;
      default:     state_next = EXC_IDLE;
    endcase
  end

  always_comb begin
    takenHandler = (state == EXC_TAKE);
    exl          = (state != EXC_IDLE);
  end

  // Accept capture is ordered after the MTC0 path so it wins a same-cycle EPC write.
  always_ff @(posedge clock) begin
    if (reset) begin
      epc_q  <= '0;
      ie_q   <= 1'b0;
      im_q   <= '0;
      ip_q   <= '0;
      code_q <= '0;
    end else begin
      ip_q <= irq_ext;
      if (cp0_we && (cp0_addr == CP0_STATUS)) begin
        ie_q <= cp0_wdata[0];
        im_q <= cp0_wdata[11:8];
      end
      if (cp0_we && (cp0_addr == CP0_EPC))
        epc_q <= cp0_wdata;
      if (accept) begin
        epc_q  <= accept_epc;
        code_q <= accept_code;
      end
    end
  end

  assign EPC = epc_q;

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_STATUS:  cp0_rdata = {52'd0, im_q, im7_q, 6'd0, ie_q};
      CP0_CAUSE:   cp0_rdata = pack_cause(ip_q, timer_ip, code_q);
      CP0_EPC:     cp0_rdata = epc_q;
`ifdef EXC_TIMER_IRQ_EN
      CP0_COUNT:   cp0_rdata = timer_count;
      CP0_COMPARE: cp0_rdata = timer_compare;
`endif
      default:     cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios plus randomized run against a reference model.
module tb_exception_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic [63:0] ex_pc = '0;
  logic        ex_bad_instr = 1'b0;
  logic        ex_overflow = 1'b0;
  logic        ex_syscall = 1'b0;
  logic [3:0]  irq_ext = '0;
  logic        eret = 1'b0;
  logic        cp0_we = 1'b0;
  logic [4:0]  cp0_addr = '0;
  logic [63:0] cp0_wdata = '0;
  logic [63:0] cp0_rdata;
  logic        takenHandler;
  logic [63:0] EPC;
  logic        exl;

  int n_checks = 0;
  int n_errors = 0;

`ifdef EXC_TIMER_IRQ_EN
  localparam logic [63:0] STATUS_MASK = 64'hF81;
`else
  localparam logic [63:0] STATUS_MASK = 64'hF01;
`endif

  exception_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .ex_bad_instr (ex_bad_instr),
    .ex_overflow  (ex_overflow),
    .ex_syscall   (ex_syscall),
    .irq_ext      (irq_ext),
    .eret         (eret),
    .cp0_we       (cp0_we),
    .cp0_addr     (cp0_addr),
    .cp0_wdata    (cp0_wdata),
    .cp0_rdata    (cp0_rdata),
    .takenHandler (takenHandler),
    .EPC          (EPC),
    .exl          (exl)
  );

  always #5 clock = ~clock;

  task automatic clear_inputs;
    ex_valid = 0; ex_pc = '0; ex_bad_instr = 0; ex_overflow = 0; ex_syscall = 0;
    irq_ext = '0; eret = 0; cp0_we = 0; cp0_addr = '0; cp0_wdata = '0;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic cp0_write(input logic [4:0] a, input logic [63:0] d);
    cp0_we = 1; cp0_addr = a; cp0_wdata = d;
    tick;
    cp0_we = 0;
  endtask

  task automatic cp0_read(input logic [4:0] a, output logic [63:0] v);
    cp0_addr = a;
    #1;
    v = cp0_rdata;
  endtask

  // Reset, then park Compare far away so the timer stays silent in non-timer scenarios.
  task automatic do_reset;
    reset = 1;
    clear_inputs;
    tick; tick;
    reset = 0;
    tick;
`ifdef EXC_TIMER_IRQ_EN
    cp0_write(5'd11, '1);
`endif
  endtask

  task automatic test_reset;
    logic [63:0] v;
    reset = 1;
    ex_valid = 1; ex_overflow = 1; ex_pc = 64'hABC0; irq_ext = 4'hF;
    cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = '1;
    tick; tick;
    n_checks++; if (takenHandler !== 1'b0) begin n_errors++; $display("FAIL reset_taken: got %b expected 0", takenHandler); end
    n_checks++; if (exl !== 1'b0) begin n_errors++; $display("FAIL reset_exl: got %b expected 0", exl); end
    n_checks++; if (EPC !== 64'd0) begin n_errors++; $display("FAIL reset_epc: got %h expected 0", EPC); end
    cp0_we = 0;
    cp0_read(5'd12, v);
    n_checks++; if (v !== 64'd0) begin n_errors++; $display("FAIL reset_status: got %h expected 0", v); end
    cp0_read(5'd13, v);
    n_checks++; if (v !== 64'd0) begin n_errors++; $display("FAIL reset_cause: got %h expected 0", v); end
    do_reset;
  endtask

  task automatic test_overflow;
    logic [63:0] v;
    do_reset;
    ex_valid = 1; ex_overflow = 1; ex_pc = 64'h1000;
    #1;
    n_checks++; if (takenHandler !== 1'b0) begin n_errors++; $display("FAIL ov_early: got %b expected 0", takenHandler); end
    tick;
    clear_inputs;
    n_checks++; if (takenHandler !== 1'b1) begin n_errors++; $display("FAIL ov_pulse: got %b expected 1", takenHandler); end
    n_checks++; if (EPC !== 64'h1000) begin n_errors++; $display("FAIL ov_epc: got %h expected 1000", EPC); end
    n_checks++; if (exl !== 1'b1) begin n_errors++; $display("FAIL ov_exl: got %b expected 1", exl); end
    cp0_read(5'd13, v);
    n_checks++; if (v[6:2] !== 5'd12) begin n_errors++; $display("FAIL ov_code: got %0d expected 12", v[6:2]); end
    tick;
    n_checks++; if (takenHandler !== 1'b0) begin n_errors++; $display("FAIL ov_single: got %b expected 0", takenHandler); end
    n_checks++; if (exl !== 1'b1) begin n_errors++; $display("FAIL ov_handler_exl: got %b expected 1", exl); end
    eret = 1; tick; eret = 0;
    n_checks++; if (exl !== 1'b0) begin n_errors++; $display("FAIL ov_eret: got %b expected 0", exl); end
  endtask

  task automatic test_priority;
    logic [63:0] v;
    do_reset;
    ex_valid = 1; ex_bad_instr = 1; ex_syscall = 1; ex_pc = 64'h2000;
    tick;
    clear_inputs;
    cp0_read(5'd13, v);
    n_checks++; if (takenHandler !== 1'b1) begin n_errors++; $display("FAIL prio_pulse: got %b expected 1", takenHandler); end
    n_checks++; if (v[6:2] !== 5'd10) begin n_errors++; $display("FAIL prio_code: got %0d expected 10", v[6:2]); end
    n_checks++; if (EPC !== 64'h2000) begin n_errors++; $display("FAIL prio_epc: got %h expected 2000", EPC); end
    tick;
    n_checks++; if (takenHandler !== 1'b0) begin n_errors++; $display("FAIL prio_single: got %b expected 0", takenHandler); end
    eret = 1; tick; eret = 0;
    ex_valid = 1; ex_syscall = 1; ex_pc = 64'h2100;
    tick;
    clear_inputs;
    cp0_read(5'd13, v);
    n_checks++; if (v[6:2] !== 5'd8) begin n_errors++; $display("FAIL sys_code: got %0d expected 8", v[6:2]); end
    tick; eret = 1; tick; eret = 0;
    ex_valid = 0; ex_overflow = 1; ex_pc = 64'h2200;
    tick; tick;
    clear_inputs;
    n_checks++; if (takenHandler !== 1'b0 || exl !== 1'b0) begin n_errors++; $display("FAIL bubble: got taken=%b exl=%b expected 0 0", takenHandler, exl); end
  endtask

  task automatic test_interrupt;
    logic [63:0] v;
    do_reset;
    cp0_write(5'd12, 64'h101);
    cp0_read(5'd12, v);
    n_checks++; if (v !== 64'h101) begin n_errors++; $display("FAIL irq_status: got %h expected 101", v); end
    irq_ext = 4'b0001; ex_pc = 64'h3000;
    tick;
    irq_ext = 4'b0000;
    cp0_read(5'd13, v);
    n_checks++; if (takenHandler !== 1'b1) begin n_errors++; $display("FAIL irq_pulse: got %b expected 1", takenHandler); end
    n_checks++; if (EPC !== 64'h3004) begin n_errors++; $display("FAIL irq_epc: got %h expected 3004", EPC); end
    n_checks++; if (v[6:2] !== 5'd0) begin n_errors++; $display("FAIL irq_code: got %0d expected 0", v[6:2]); end
    tick; eret = 1; tick; eret = 0;
    irq_ext = 4'b0100; ex_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick;
    n_checks++; if (takenHandler !== 1'b0) begin n_errors++; $display("FAIL irq_masked: got %b expected 0", takenHandler); end
    irq_ext = 4'b0001;
    tick;
    irq_ext = 4'b0000;
    n_checks++; if (EPC !== 64'd0) begin n_errors++; $display("FAIL irq_wrap: got %h expected 0", EPC); end
    do_reset;
    cp0_write(5'd12, 64'h100);
    irq_ext = 4'b0001; ex_pc = 64'h3000;
    tick; tick;
    cp0_read(5'd13, v);
    n_checks++; if (takenHandler !== 1'b0 || exl !== 1'b0) begin n_errors++; $display("FAIL irq_ie0: got taken=%b exl=%b expected 0 0", takenHandler, exl); end
    n_checks++; if (v !== 64'h100) begin n_errors++; $display("FAIL irq_ip8: got %h expected 100", v); end
    clear_inputs;
  endtask

  task automatic test_handler_ignore;
    logic [63:0] v;
    logic [63:0] cause_before;
    do_reset;
    cp0_write(5'd12, 64'hF01);
    ex_valid = 1; ex_overflow = 1; ex_pc = 64'h1000;
    tick; tick;
    ex_pc = 64'h7000; irq_ext = 4'hF; ex_syscall = 1;
    tick;
    n_checks++; if (takenHandler !== 1'b0) begin n_errors++; $display("FAIL hdl_ignore1: got %b expected 0", takenHandler); end
    tick;
    n_checks++; if (takenHandler !== 1'b0) begin n_errors++; $display("FAIL hdl_ignore2: got %b expected 0", takenHandler); end
    n_checks++; if (EPC !== 64'h1000) begin n_errors++; $display("FAIL hdl_epc_kept: got %h expected 1000", EPC); end
    clear_inputs;
    eret = 1; tick; eret = 0;
    n_checks++; if (exl !== 1'b0) begin n_errors++; $display("FAIL hdl_eret: got %b expected 0", exl); end
    cp0_read(5'd13, cause_before);
    eret = 1; tick; eret = 0;
    cp0_read(5'd13, v);
    n_checks++; if (exl !== 1'b0 || takenHandler !== 1'b0) begin n_errors++; $display("FAIL idle_eret_fsm: got exl=%b taken=%b expected 0 0", exl, takenHandler); end
    n_checks++; if (EPC !== 64'h1000 || v !== cause_before) begin n_errors++; $display("FAIL idle_eret_regs: got epc=%h cause=%h expected 1000 %h", EPC, v, cause_before); end
  endtask

  task automatic test_reset_mid_take;
    do_reset;
    ex_valid = 1; ex_overflow = 1; ex_pc = 64'h1000;
    tick;
    reset = 1;
    tick;
    n_checks++; if (takenHandler !== 1'b0 || exl !== 1'b0) begin n_errors++; $display("FAIL rst_take_fsm: got taken=%b exl=%b expected 0 0", takenHandler, exl); end
    n_checks++; if (EPC !== 64'd0) begin n_errors++; $display("FAIL rst_take_epc: got %h expected 0", EPC); end
    do_reset;
  endtask

  task automatic test_cp0_map;
    logic [63:0] v;
    do_reset;
    cp0_write(5'd13, '1);
    cp0_read(5'd13, v);
    n_checks++; if (v !== 64'd0) begin n_errors++; $display("FAIL cause_wr_ignored: got %h expected 0", v); end
    cp0_write(5'd14, 64'hDEAD_BEEF_0000_1234);
    cp0_read(5'd14, v);
    n_checks++; if (v !== 64'hDEAD_BEEF_0000_1234 || EPC !== v) begin n_errors++; $display("FAIL epc_mtc0: got rd=%h port=%h expected deadbeef00001234", v, EPC); end
    cp0_write(5'd20, '1);
    cp0_read(5'd20, v);
    n_checks++; if (v !== 64'd0) begin n_errors++; $display("FAIL unmapped_rd: got %h expected 0", v); end
    cp0_read(5'd12, v);
    n_checks++; if (v !== 64'd0) begin n_errors++; $display("FAIL unmapped_wr: got %h expected 0", v); end
    ex_valid = 1; ex_overflow = 1; ex_pc = 64'h4000;
    cp0_we = 1; cp0_addr = 5'd14; cp0_wdata = 64'h5555;
    tick;
    clear_inputs;
    n_checks++; if (EPC !== 64'h4000) begin n_errors++; $display("FAIL epc_race: got %h expected 4000", EPC); end
    do_reset;
`ifndef EXC_TIMER_IRQ_EN
    cp0_write(5'd9, 64'd123);
    cp0_write(5'd11, 64'd77);
    tick; tick;
    cp0_read(5'd9, v);
    n_checks++; if (v !== 64'd0) begin n_errors++; $display("FAIL count_absent: got %h expected 0", v); end
    cp0_read(5'd11, v);
    n_checks++; if (v !== 64'd0) begin n_errors++; $display("FAIL compare_absent: got %h expected 0", v); end
    cp0_read(5'd13, v);
    n_checks++; if (v[7] !== 1'b0) begin n_errors++; $display("FAIL ip7_absent: got %b expected 0", v[7]); end
`endif
  endtask

`ifdef EXC_TIMER_IRQ_EN
  task automatic test_timer;
    logic [63:0] v;
    logic [63:0] c1;
    bit seen;
    reset = 1; clear_inputs;
    tick; tick;
    reset = 0;
    tick;
    cp0_write(5'd11, 64'd5);
    cp0_write(5'd12, 64'h81);
    ex_pc = 64'h5000;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick;
      if (takenHandler === 1'b1) seen = 1;
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL timer_pulse: got no pulse expected pulse within 20 cycles"); end
    cp0_read(5'd9, v);
    n_checks++; if (v < 64'd5 || v > 64'd10) begin n_errors++; $display("FAIL timer_when: got count %0d expected 5..10", v); end
    cp0_read(5'd13, v);
    n_checks++; if (v[7] !== 1'b1 || v[6:2] !== 5'd0) begin n_errors++; $display("FAIL timer_cause: got ip7=%b code=%0d expected 1 0", v[7], v[6:2]); end
    n_checks++; if (EPC !== 64'h5004) begin n_errors++; $display("FAIL timer_epc: got %h expected 5004", EPC); end
    tick;
    cp0_read(5'd9, c1);
    tick;
    cp0_read(5'd9, v);
    n_checks++; if (v !== c1 + 64'd1) begin n_errors++; $display("FAIL timer_count: got %0d expected %0d", v, c1 + 64'd1); end
    cp0_write(5'd11, 64'h10_0000);
    cp0_read(5'd13, v);
    n_checks++; if (v[7] !== 1'b0) begin n_errors++; $display("FAIL timer_clear: got %b expected 0", v[7]); end
    cp0_read(5'd11, v);
    n_checks++; if (v !== 64'h10_0000) begin n_errors++; $display("FAIL timer_compare_rd: got %h expected 100000", v); end
    eret = 1; tick; eret = 0;
    tick;
    n_checks++; if (exl !== 1'b0 || takenHandler !== 1'b0) begin n_errors++; $display("FAIL timer_done: got exl=%b taken=%b expected 0 0", exl, takenHandler); end
    clear_inputs;
  endtask
`endif

  task automatic test_random;
    logic        m_busy, m_pulse;
    logic [63:0] m_epc, m_status;
    logic [3:0]  m_ip;
    logic [4:0]  m_code;
    logic        n_busy, n_pulse;
    logic [63:0] n_epc, n_status;
    logic [4:0]  n_code;
    logic [63:0] exp_rd;
    logic        sync, intr;
    do_reset;
    m_busy = 0; m_pulse = 0; m_epc = '0; m_status = '0; m_ip = '0; m_code = '0;
    for (int i = 0; i < 600; i++) begin
      ex_valid     = 1'($urandom_range(0, 1));
      ex_bad_instr = ($urandom_range(0, 7) == 0);
      ex_overflow  = ($urandom_range(0, 7) == 0);
      ex_syscall   = ($urandom_range(0, 7) == 0);
      ex_pc        = {$urandom, $urandom};
      irq_ext      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      eret         = ($urandom_range(0, 3) == 0);
      cp0_we       = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: cp0_addr = 5'd3;
        1: cp0_addr = 5'd12;
        2: cp0_addr = 5'd13;
        3: cp0_addr = 5'd14;
        default: cp0_addr = 5'd20;
      endcase
      cp0_wdata = {$urandom, $urandom};
      #1;
      case (cp0_addr)
        5'd12: exp_rd = m_status;
        5'd13: exp_rd = (64'(m_ip) << 8) | (64'(m_code) << 2);
        5'd14: exp_rd = m_epc;
        default: exp_rd = '0;
      endcase
      n_checks++; if (cp0_rdata !== exp_rd) begin n_errors++; $display("FAIL rnd_rdata[%0d] addr %0d: got %h expected %h", i, cp0_addr, cp0_rdata, exp_rd); end
      n_status = m_status; n_epc = m_epc; n_code = m_code; n_busy = m_busy; n_pulse = 0;
      if (cp0_we && cp0_addr == 5'd12) n_status = cp0_wdata & STATUS_MASK;
      if (cp0_we && cp0_addr == 5'd14) n_epc = cp0_wdata;
      sync = ex_valid && (ex_bad_instr || ex_overflow || ex_syscall);
      intr = m_status[0] && ((irq_ext & m_status[11:8]) != 4'd0);
      if (!m_busy) begin
        if (sync || intr) begin
          n_busy = 1; n_pulse = 1;
          n_epc  = sync ? ex_pc : ex_pc + 64'd4;
          n_code = !sync ? 5'd0 : ex_bad_instr ? 5'd10 : ex_overflow ? 5'd12 : 5'd8;
        end
      end else if (!m_pulse && eret) begin
        n_busy = 0;
      end
      m_ip = irq_ext;
      tick;
      m_status = n_status; m_epc = n_epc; m_code = n_code; m_busy = n_busy; m_pulse = n_pulse;
      n_checks++; if (takenHandler !== m_pulse || exl !== m_busy) begin n_errors++; $display("FAIL rnd_fsm[%0d]: got taken=%b exl=%b expected %b %b", i, takenHandler, exl, m_pulse, m_busy); end
      n_checks++; if (EPC !== m_epc) begin n_errors++; $display("FAIL rnd_epc[%0d]: got %h expected %h", i, EPC, m_epc); end
    end
    clear_inputs;
  endtask

  initial begin
    clear_inputs;
    test_reset;
    test_overflow;
    test_priority;
    test_interrupt;
    test_handler_ignore;
    test_reset_mid_take;
    test_cp0_map;
`ifdef EXC_TIMER_IRQ_EN
    test_timer;
`endif
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
